// File: rtl/cpu_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// Package: cpu_ctrl_pkg
// Purpose: Shared definitions for the execute-stage control-flow logic.
//   - PNZ flag bit positions (P=2, N=1, Z=0)
//   - default PC/target address width
//   - helper that evaluates a PNZ condition mask against a flag vector
// Ports:   none (package)
// ---------------------------------------------------------------------------
package cpu_ctrl_pkg;

    localparam int ADDR_W_DEFAULT = 16;

    localparam int PNZ_P = 2;
    localparam int PNZ_N = 1;
    localparam int PNZ_Z = 0;

    typedef logic [2:0] pnz_t;

    // A branch condition is met when any flag selected by the mask is set.
    function automatic logic cond_met(input pnz_t cond, input pnz_t flags);
        return (cond[PNZ_P] & flags[PNZ_P]) |
               (cond[PNZ_N] & flags[PNZ_N]) |
               (cond[PNZ_Z] & flags[PNZ_Z]);
    endfunction

endpackage

// File: rtl/ctrl_lifo.sv
// ---------------------------------------------------------------------------
// Module: ctrl_lifo
// Purpose: Small register-based LIFO used for the return-address stack and
//          the interrupt-PC stack.
//   WRAP=1: a push while full overwrites the oldest entry (circular), count
//           stays at DEPTH.
//   WRAP=0: a push while full is dropped.
//   Pop while empty is a no-op; top reads 0 whenever the stack is empty.
//   Push and pop together on a non-empty stack replace the top entry.
//   Push and pop together on an empty stack behave as a plain push.
// Ports:
//   clk      in   1       clock
//   rst_n    in   1       async active-low reset (clears entries and count)
//   push_i   in   1       push din_i
//   pop_i    in   1       pop top entry
//   din_i    in   W       data to push
//   top_o    out  W       current top entry (0 when empty)
//   count_o  out  CW      number of valid entries
//   full_o   out  1       count_o == DEPTH
// ---------------------------------------------------------------------------
module ctrl_lifo #(
    parameter int W     = 16,
    parameter int DEPTH = 8,
    parameter bit WRAP  = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [W-1:0]               din_i,
    output logic [W-1:0]               top_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o
);

    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int SLOTS = 1 << PW;

    logic [W-1:0]  mem_q [SLOTS];
    logic [PW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] top_idx;
    logic [PW-1:0] wr_idx;
    logic          wr_en;
    logic          empty;

    // ptr_q always points at the next free slot; when full with WRAP=1 that
    // slot holds the oldest entry, which is exactly the one to overwrite.
    assign top_idx = ptr_q - PW'(1);
    assign empty   = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign top_o   = empty ? '0 : mem_q[top_idx];
    assign count_o = count_q;

    // Next-state for pointer/count and the single write port.
    always_comb begin
        ptr_d   = ptr_q;
        count_d = count_q;
        wr_en   = 1'b0;
        wr_idx  = ptr_q;
        if (push_i && pop_i && !empty) begin
            wr_en  = 1'b1;
            wr_idx = top_idx;
        end else if (push_i) begin
            if (!full_o) begin
                wr_en   = 1'b1;
                ptr_d   = ptr_q + PW'(1);
                count_d = count_q + CW'(1);
            end else if (WRAP) begin
                wr_en = 1'b1;
                ptr_d = ptr_q + PW'(1);
            end
        end else if (pop_i && !empty) begin
            ptr_d   = ptr_q - PW'(1);
            count_d = count_q - CW'(1);
        end
    end

    // Storage and pointers; everything clears on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q   <= '0;
            count_q <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
            if (wr_en) begin
                mem_q[wr_idx] <= din_i;
            end
        end
    end

endmodule

// File: rtl/branch_ctrl_unit.sv
// ---------------------------------------------------------------------------
// Module: branch_ctrl_unit
// Purpose: Execute-stage control-flow resolver. Holds the PNZ flags, resolves
//          conditional branches, calls and returns, keeps a return-address
//          stack (circular) and a nestable interrupt-PC stack, and drives the
//          fetch-stage redirect.
// Configuration macro: FLAG_BYPASS_EN
//   defined   : a branch sees pnz_new when flag_we is set in the same cycle
//   undefined : a branch always sees the registered flags pnz_q
// Ports:
//   clk, rst_n     clock, async active-low reset
//   ex_valid       EX instruction valid; gates every state update
//   pc             PC of the EX instruction
//   alu_target     branch target computed by the ALU
//   br, cond       conditional branch and its PNZ mask
//   save_addr      branch is a call (push pc+1 when taken)
//   ret            return from call or interrupt
//   flag_we        load pnz_new into the flags
//   pnz_new        flags produced by the ALU
//   int_req        interrupt request
//   branch_addr    redirect target
//   branch_taken   redirect fetch this cycle
//   int_ack        interrupt accepted this cycle
//   int_state_out  inside an interrupt handler (int_level != 0)
//   int_level      current interrupt nesting depth
//   pnz_q          registered flags
//   ras_ovf        sticky: push while RAS full
//   ras_unf        sticky: pop while RAS empty
// ---------------------------------------------------------------------------
module branch_ctrl_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEFAULT,
    parameter int RAS_DEPTH = 8,
    parameter int INT_DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           ex_valid,
    input  logic [ADDR_W-1:0]              pc,
    input  logic [ADDR_W-1:0]              alu_target,
    input  logic                           br,
    input  logic [2:0]                     cond,
    input  logic                           save_addr,
    input  logic                           ret,
    input  logic                           flag_we,
    input  logic [2:0]                     pnz_new,
    input  logic                           int_req,
    output logic [ADDR_W-1:0]              branch_addr,
    output logic                           branch_taken,
    output logic                           int_ack,
    output logic                           int_state_out,
    output logic [$clog2(INT_DEPTH+1)-1:0] int_level,
    output logic [2:0]                     pnz_q,
    output logic                           ras_ovf,
    output logic                           ras_unf
);

    localparam int RCW = $clog2(RAS_DEPTH + 1);

    logic [ADDR_W-1:0] ras_top, int_top, pc_inc;
    logic [RCW-1:0]    ras_count;
    logic              ras_full, ras_empty, int_full;
    logic              active, in_int, taken_br;
    logic              ret_int, ret_ras, ras_push;
    pnz_t              flags_eff, pnz_d;
    logic              ras_ovf_q, ras_ovf_d, ras_unf_q, ras_unf_d;

    // An accepted interrupt squashes the EX instruction: it will be
    // re-executed on return, so it must not redirect or touch any state.
    assign int_ack = ex_valid & int_req & ~int_full;
    assign active  = ex_valid & ~int_ack;
    assign in_int  = (int_level != '0);

`ifdef FLAG_BYPASS_EN
    assign flags_eff = flag_we ? pnz_new : pnz_q;
`else
    assign flags_eff = pnz_q;
`endif

    assign taken_br  = br & cond_met(cond, flags_eff);
    assign pc_inc    = pc + ADDR_W'(1);
    assign ras_empty = (ras_count == '0);

    // A return inside a handler unwinds the interrupt stack only.
    assign ret_int  = active & ret & in_int;
    assign ret_ras  = active & ret & ~in_int;
    assign ras_push = active & save_addr & taken_br & ~ret_int;

    assign branch_taken  = active & (taken_br | ret);
    assign int_state_out = in_int;
    assign ras_ovf       = ras_ovf_q;
    assign ras_unf       = ras_unf_q;

    // Redirect target; held at zero when the instruction is invalid or squashed.
    always_comb begin
        branch_addr = '0;
        if (active) begin
            if (ret) begin
                branch_addr = in_int ? int_top : ras_top;
            end else begin
                branch_addr = alu_target;
            end
        end
    end

    // Flag and sticky-status next state. A simultaneous push+pop on a full
    // RAS is a replace, not an overflow.
    always_comb begin
        pnz_d     = pnz_q;
        ras_ovf_d = ras_ovf_q;
        ras_unf_d = ras_unf_q;
        if (active && flag_we) begin
            pnz_d = pnz_new;
        end
        if (ras_push && ras_full && !ret_ras) begin
            ras_ovf_d = 1'b1;
        end
        if (ret_ras && ras_empty) begin
            ras_unf_d = 1'b1;
        end
    end

    // Flag and sticky-status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pnz_q     <= '0;
            ras_ovf_q <= 1'b0;
            ras_unf_q <= 1'b0;
        end else begin
            pnz_q     <= pnz_d;
            ras_ovf_q <= ras_ovf_d;
            ras_unf_q <= ras_unf_d;
        end
    end

    ctrl_lifo #(
        .W     (ADDR_W),
        .DEPTH (RAS_DEPTH),
        .WRAP  (1'b1)
    ) u_ras (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (ras_push),
        .pop_i   (ret_ras),
        .din_i   (pc_inc),
        .top_o   (ras_top),
        .count_o (ras_count),
        .full_o  (ras_full)
    );

    ctrl_lifo #(
        .W     (ADDR_W),
        .DEPTH (INT_DEPTH),
        .WRAP  (1'b0)
    ) u_int_stack (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (int_ack),
        .pop_i   (ret_int),
        .din_i   (pc),
        .top_o   (int_top),
        .count_o (int_level),
        .full_o  (int_full)
    );

endmodule

// File: tb/tb_branch_ctrl_unit.sv
// Self-checking bench for branch_ctrl_unit (default parameters 16/8/2).
// A queue-based reference model tracks flags, RAS and interrupt stack.
module tb_branch_ctrl_unit;

    localparam int RAS_D = 8;
    localparam int INT_D = 2;
`ifdef FLAG_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef struct {
        logic        ex_valid;
        logic [15:0] pc;
        logic [15:0] alu_target;
        logic        br;
        logic [2:0]  cond;
        logic        save_addr;
        logic        ret;
        logic        flag_we;
        logic [2:0]  pnz_new;
        logic        int_req;
        logic        exp_taken;
        logic [15:0] exp_addr;
        logic        exp_ack;
    } vec_t;

    logic        clk, rst_n;
    logic        ex_valid, br, save_addr, ret, flag_we, int_req;
    logic [15:0] pc, alu_target;
    logic [2:0]  cond, pnz_new;
    logic [15:0] branch_addr;
    logic        branch_taken, int_ack, int_state_out;
    logic [1:0]  int_level;
    logic [2:0]  pnz_q;
    logic        ras_ovf, ras_unf;

    int passCount  = 0;
    int checkCount = 0;

    // reference model state
    logic [15:0] mRas[$];
    logic [15:0] mInt[$];
    logic [2:0]  mPnz;
    logic        mOvf, mUnf;

    branch_ctrl_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ex_valid      (ex_valid),
        .pc            (pc),
        .alu_target    (alu_target),
        .br            (br),
        .cond          (cond),
        .save_addr     (save_addr),
        .ret           (ret),
        .flag_we       (flag_we),
        .pnz_new       (pnz_new),
        .int_req       (int_req),
        .branch_addr   (branch_addr),
        .branch_taken  (branch_taken),
        .int_ack       (int_ack),
        .int_state_out (int_state_out),
        .int_level     (int_level),
        .pnz_q         (pnz_q),
        .ras_ovf       (ras_ovf),
        .ras_unf       (ras_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mkVec(logic ev, logic [15:0] p, logic [15:0] alu, logic b,
                                   logic [2:0] c, logic sa, logic r, logic fwe,
                                   logic [2:0] pn, logic ir, logic et,
                                   logic [15:0] ea, logic eack);
        vec_t v;
        v.ex_valid = ev;  v.pc = p;        v.alu_target = alu; v.br = b;
        v.cond = c;       v.save_addr = sa; v.ret = r;         v.flag_we = fwe;
        v.pnz_new = pn;   v.int_req = ir;  v.exp_taken = et;   v.exp_addr = ea;
        v.exp_ack = eack;
        return v;
    endfunction

    function automatic vec_t idleVec();
        return mkVec(1'b0, 16'h0, 16'h0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0,
                     1'b0, 16'h0, 1'b0);
    endfunction

    // ---------------- reference model ----------------
    function automatic logic [2:0] modelFlags(vec_t v);
        if (BYPASS && v.flag_we) return v.pnz_new;
        return mPnz;
    endfunction

    function automatic logic modelAck(vec_t v);
        return v.ex_valid && v.int_req && (mInt.size() < INT_D);
    endfunction

    function automatic logic modelTakenBr(vec_t v);
        return v.br && ((v.cond & modelFlags(v)) != 3'b000);
    endfunction

    function automatic logic modelActive(vec_t v);
        return v.ex_valid && !modelAck(v);
    endfunction

    function automatic logic modelTaken(vec_t v);
        return modelActive(v) && (modelTakenBr(v) || v.ret);
    endfunction

    function automatic logic [15:0] modelAddr(vec_t v);
        if (!modelActive(v)) return 16'h0;
        if (!v.ret) return v.alu_target;
        if (mInt.size() != 0) return mInt[$];
        if (mRas.size() != 0) return mRas[$];
        return 16'h0;
    endfunction

    task automatic modelReset();
        mRas.delete();
        mInt.delete();
        mPnz = 3'b000;
        mOvf = 1'b0;
        mUnf = 1'b0;
    endtask

    task automatic modelUpdate(vec_t v);
        logic        tb;
        logic [15:0] nxt;
        tb  = modelTakenBr(v);
        nxt = v.pc + 16'd1;
        if (modelAck(v)) begin
            mInt.push_back(v.pc);
        end else if (v.ex_valid) begin
            if (v.flag_we) mPnz = v.pnz_new;
            if (v.ret && mInt.size() != 0) begin
                void'(mInt.pop_back());
            end else if (v.ret && v.save_addr && tb) begin
                if (mRas.size() == 0) begin
                    mUnf = 1'b1;
                    mRas.push_back(nxt);
                end else begin
                    mRas[mRas.size()-1] = nxt;
                end
            end else if (v.save_addr && tb) begin
                if (mRas.size() == RAS_D) begin
                    void'(mRas.pop_front());
                    mOvf = 1'b1;
                end
                mRas.push_back(nxt);
            end else if (v.ret) begin
                if (mRas.size() == 0) mUnf = 1'b1;
                else void'(mRas.pop_back());
            end
        end
    endtask

    // ---------------- bench tasks ----------------
    task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic applyStimulus(vec_t v);
        ex_valid   = v.ex_valid;
        pc         = v.pc;
        alu_target = v.alu_target;
        br         = v.br;
        cond       = v.cond;
        save_addr  = v.save_addr;
        ret        = v.ret;
        flag_we    = v.flag_we;
        pnz_new    = v.pnz_new;
        int_req    = v.int_req;
        #2;
    endtask

    task automatic checkModel(vec_t v);
        checkOutput("taken",    32'(branch_taken),  32'(modelTaken(v)));
        checkOutput("addr",     32'(branch_addr),   32'(modelAddr(v)));
        checkOutput("ack",      32'(int_ack),       32'(modelAck(v)));
        checkOutput("level",    32'(int_level),     32'(mInt.size()));
        checkOutput("intState", 32'(int_state_out), 32'(mInt.size() != 0));
        checkOutput("pnz",      32'(pnz_q),         32'(mPnz));
        checkOutput("ovf",      32'(ras_ovf),       32'(mOvf));
        checkOutput("unf",      32'(ras_unf),       32'(mUnf));
    endtask

    task automatic tick(vec_t v);
        @(posedge clk);
        modelUpdate(v);
        @(negedge clk);
    endtask

    task automatic step(vec_t v);
        applyStimulus(v);
        checkModel(v);
        tick(v);
    endtask

    task automatic resetDut();
        applyStimulus(idleVec());
        rst_n = 1'b0;
        modelReset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic setFlags(logic [2:0] f);
        step(mkVec(1'b1, 16'h0, 16'h0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, f, 1'b0,
                   1'b0, 16'h0, 1'b0));
    endtask

    // ---------------- test sequence ----------------
    initial begin
        vec_t tbl[$];
        vec_t v;

        rst_n = 1'b0;
        resetDut();
        checkOutput("rstPnz",   32'(pnz_q),     32'h0);
        checkOutput("rstLevel", 32'(int_level), 32'h0);
        checkOutput("rstOvf",   32'(ras_ovf),   32'h0);
        checkOutput("rstUnf",   32'(ras_unf),   32'h0);

        // table: call/return basics, replace, invalid cycle, flag bypass
        tbl.push_back(mkVec(1, 16'h0000, 16'h0000, 0, 3'b000, 0, 0, 1, 3'b001, 0, 0, 16'h0000, 0));
        tbl.push_back(mkVec(1, 16'h0010, 16'h0200, 1, 3'b001, 1, 0, 0, 3'b000, 0, 1, 16'h0200, 0));
        tbl.push_back(mkVec(1, 16'h0200, 16'h0000, 0, 3'b000, 0, 1, 0, 3'b000, 0, 1, 16'h0011, 0));
        tbl.push_back(mkVec(1, 16'h0AA9, 16'h0040, 1, 3'b001, 1, 0, 0, 3'b000, 0, 1, 16'h0040, 0));
        tbl.push_back(mkVec(1, 16'h0020, 16'h0077, 1, 3'b001, 1, 1, 0, 3'b000, 0, 1, 16'h0AAA, 0));
        tbl.push_back(mkVec(1, 16'h0030, 16'h0000, 0, 3'b000, 0, 1, 0, 3'b000, 0, 1, 16'h0021, 0));
        tbl.push_back(mkVec(1, 16'h0031, 16'h0000, 0, 3'b000, 0, 1, 0, 3'b000, 0, 1, 16'h0000, 0));
        tbl.push_back(mkVec(0, 16'h0040, 16'h0555, 1, 3'b111, 1, 1, 1, 3'b111, 1, 0, 16'h0000, 0));
        tbl.push_back(mkVec(1, 16'h0041, 16'h0005, 0, 3'b000, 0, 0, 1, 3'b000, 0, 0, 16'h0005, 0));
        tbl.push_back(mkVec(1, 16'h0042, 16'h0123, 1, 3'b100, 0, 0, 1, 3'b100, 0, BYPASS, 16'h0123, 0));
        tbl.push_back(mkVec(1, 16'h0043, 16'h0124, 1, 3'b100, 0, 0, 0, 3'b000, 0, 1, 16'h0124, 0));
        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i]);
            checkModel(tbl[i]);
            checkOutput($sformatf("tblTaken%0d", i), 32'(branch_taken), 32'(tbl[i].exp_taken));
            checkOutput($sformatf("tblAddr%0d", i),  32'(branch_addr),  32'(tbl[i].exp_addr));
            checkOutput($sformatf("tblAck%0d", i),   32'(int_ack),      32'(tbl[i].exp_ack));
            tick(tbl[i]);
        end

        // nine calls overflow the 8-deep RAS, then nine returns
        resetDut();
        setFlags(3'b001);
        for (int i = 0; i < 9; i++) begin
            step(mkVec(1, 16'h0100 + 16'(i), 16'h0800, 1, 3'b001, 1, 0, 0, 3'b000, 0,
                       0, 16'h0, 0));
        end
        checkOutput("ovfAfter9", 32'(ras_ovf), 32'h1);
        for (int i = 0; i < 9; i++) begin
            v = mkVec(1, 16'h0900, 16'h0000, 0, 3'b000, 0, 1, 0, 3'b000, 0, 0, 16'h0, 0);
            applyStimulus(v);
            checkModel(v);
            checkOutput($sformatf("retAddr%0d", i), 32'(branch_addr),
                        (i < 8) ? 32'(16'h0109 - 16'(i)) : 32'h0);
            if (i == 8) checkOutput("unfBefore", 32'(ras_unf), 32'h0);
            tick(v);
        end
        checkOutput("unfAfter", 32'(ras_unf), 32'h1);

        // nested interrupts, saturation, unwinding
        resetDut();
        setFlags(3'b001);
        v = mkVec(1, 16'h0050, 16'h0099, 1, 3'b001, 0, 0, 0, 3'b000, 1, 0, 16'h0, 0);
        applyStimulus(v); checkModel(v);
        checkOutput("int1Ack", 32'(int_ack), 32'h1);
        checkOutput("int1Taken", 32'(branch_taken), 32'h0);
        tick(v);
        checkOutput("int1Level", 32'(int_level), 32'h1);
        v = mkVec(1, 16'h0300, 16'h0000, 0, 3'b000, 0, 0, 0, 3'b000, 1, 0, 16'h0, 0);
        step(v);
        checkOutput("int2Level", 32'(int_level), 32'h2);
        v = mkVec(1, 16'h0400, 16'h0000, 0, 3'b000, 0, 0, 0, 3'b000, 1, 0, 16'h0, 0);
        applyStimulus(v); checkModel(v);
        checkOutput("int3Ack", 32'(int_ack), 32'h0);
        tick(v);
        v = mkVec(1, 16'h0401, 16'h0000, 0, 3'b000, 0, 1, 0, 3'b000, 0, 0, 16'h0, 0);
        applyStimulus(v); checkModel(v);
        checkOutput("iret1Addr", 32'(branch_addr), 32'h0300);
        tick(v);
        v.pc = 16'h0301;
        applyStimulus(v); checkModel(v);
        checkOutput("iret2Addr", 32'(branch_addr), 32'h0050);
        tick(v);
        checkOutput("iretLevel", 32'(int_level), 32'h0);

        // asynchronous reset in the middle of activity
        resetDut();
        step(mkVec(1, 16'h0000, 16'h0000, 0, 3'b000, 0, 1, 1, 3'b001, 0, 0, 16'h0, 0));
        for (int i = 0; i < 3; i++) begin
            step(mkVec(1, 16'h0700 + 16'(i), 16'h0010, 1, 3'b001, 1, 0, 0, 3'b000, 0,
                       0, 16'h0, 0));
        end
        step(mkVec(1, 16'h0710, 16'h0000, 0, 3'b000, 0, 0, 0, 3'b000, 1, 0, 16'h0, 0));
        checkOutput("preRstLevel", 32'(int_level), 32'h1);
        checkOutput("preRstUnf",   32'(ras_unf),   32'h1);
        #3;
        rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput("asyncLevel", 32'(int_level), 32'h0);
        checkOutput("asyncPnz",   32'(pnz_q),     32'h0);
        checkOutput("asyncUnf",   32'(ras_unf),   32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        v = mkVec(0, 16'h0720, 16'h0333, 1, 3'b111, 1, 1, 1, 3'b111, 1, 0, 16'h0, 0);
        step(v);
        step(v);
        v = mkVec(1, 16'h0721, 16'h0000, 0, 3'b000, 0, 1, 0, 3'b000, 0, 0, 16'h0, 0);
        applyStimulus(v); checkModel(v);
        checkOutput("postRstRet", 32'(branch_addr), 32'h0);
        tick(v);

        // randomized traffic against the reference model
        resetDut();
        for (int i = 0; i < 600; i++) begin
            v = idleVec();
            v.ex_valid   = ($urandom_range(9) != 0);
            v.pc         = 16'($urandom);
            v.alu_target = 16'($urandom);
            v.br         = ($urandom_range(1) == 1);
            v.cond       = 3'($urandom_range(7));
            v.save_addr  = ($urandom_range(2) == 0);
            v.ret        = ($urandom_range(3) == 0);
            v.flag_we    = ($urandom_range(2) == 0);
            v.pnz_new    = 3'($urandom_range(7));
            v.int_req    = ($urandom_range(9) == 0);
            step(v);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
